// File: rtl/gemm_pkg.sv
// gemm_pkg: shared FSM states, register offsets and AXI response codes for the GEMM tile sequencer.
package gemm_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CLEAR, S_FETCH, S_WAIT, S_DRAIN, S_STORE, S_DONE
  } state_t;
  localparam logic [7:0] REG_M      = 8'h00;
  localparam logic [7:0] REG_N      = 8'h04;
  localparam logic [7:0] REG_K      = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;
  localparam logic [7:0] REG_BASE_A = 8'h10;
  localparam logic [7:0] REG_BASE_B = 8'h14;
  localparam logic [7:0] REG_BASE_C = 8'h18;
  localparam logic [7:0] REG_STATUS = 8'h1C;
  localparam logic [7:0] REG_CYCLES = 8'h20;
  localparam logic [7:0] REG_STALL  = 8'h24;
  localparam logic [7:0] REG_TILES  = 8'h28;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/gemm_axil_regs.sv
// gemm_axil_regs: AXI4-Lite slave and register file of the GEMM tile sequencer.
// STALL/TILES registers exist only when GEMM_PERF_CNT_EN is defined.
module gemm_axil_regs import gemm_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [DIM_WIDTH-1:0]  m,
  output logic [DIM_WIDTH-1:0]  n,
  output logic [DIM_WIDTH-1:0]  k,
  output logic [ADDR_WIDTH-1:0] base_a,
  output logic [ADDR_WIDTH-1:0] base_b,
  output logic [ADDR_WIDTH-1:0] base_c,
  output logic                  accum,
  output logic                  irq_en,
  output logic                  start,
  output logic                  abort,
  output logic                  done_clr,
  input  logic                  busy,
  input  logic                  done,
  input  logic                  err,
`ifdef GEMM_PERF_CNT_EN
  input  logic [31:0]           stall,
  input  logic [31:0]           tiles,
`endif
  input  logic [31:0]           cycles
);
  logic [7:0] wa, ra;
  logic wa_ok, ra_ok, wr_en, wr_cfg, wr_hit, wr_ok, rd_hit;
  logic [31:0] rd_val;
  assign wa = s_axi_awaddr[7:0];
  assign ra = s_axi_araddr[7:0];
  assign wa_ok = (s_axi_awaddr >> 8) == '0;
  assign ra_ok = (s_axi_araddr >> 8) == '0;
  assign s_axi_wready = s_axi_awready;
  assign wr_en = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign wr_cfg = wa inside {REG_M, REG_N, REG_K, REG_BASE_A, REG_BASE_B, REG_BASE_C};
  assign wr_hit = wa_ok && (wr_cfg || wa == REG_CTRL || wa == REG_STATUS || wa == REG_CYCLES);
  // Geometry and bases are frozen during a run; CTRL stays writable so abort can reach the FSM.
  assign wr_ok = wr_hit && !(wr_cfg && busy);
  always_comb begin
    rd_val = '0;
    rd_hit = ra_ok;
    case (ra)
      REG_M:      rd_val = 32'(m);
      REG_N:      rd_val = 32'(n);
      REG_K:      rd_val = 32'(k);
      REG_CTRL:   rd_val = {29'd0, irq_en, accum, 1'b0};
      REG_BASE_A: rd_val = 32'(base_a);
      REG_BASE_B: rd_val = 32'(base_b);
      REG_BASE_C: rd_val = 32'(base_c);
      REG_STATUS: rd_val = {29'd0, err, done, busy};
      REG_CYCLES: rd_val = cycles;
`ifdef GEMM_PERF_CNT_EN
      REG_STALL:  rd_val = stall;
      REG_TILES:  rd_val = tiles;
`endif
      default:    rd_hit = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      m <= DIM_WIDTH'(64);
      n <= DIM_WIDTH'(64);
      k <= DIM_WIDTH'(64);
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      accum <= 1'b0;
      irq_en <= 1'b0;
      start <= 1'b0;
      abort <= 1'b0;
      done_clr <= 1'b0;
    end else begin
      start <= 1'b0;
      abort <= 1'b0;
      done_clr <= 1'b0;
      s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_awready && !s_axi_bvalid;
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (wr_en) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok)
          case (wa)
            REG_M:      m <= DIM_WIDTH'(apply_strb(32'(m), s_axi_wdata, s_axi_wstrb));
            REG_N:      n <= DIM_WIDTH'(apply_strb(32'(n), s_axi_wdata, s_axi_wstrb));
            REG_K:      k <= DIM_WIDTH'(apply_strb(32'(k), s_axi_wdata, s_axi_wstrb));
            REG_BASE_A: base_a <= ADDR_WIDTH'(apply_strb(32'(base_a), s_axi_wdata, s_axi_wstrb));
            REG_BASE_B: base_b <= ADDR_WIDTH'(apply_strb(32'(base_b), s_axi_wdata, s_axi_wstrb));
            REG_BASE_C: base_c <= ADDR_WIDTH'(apply_strb(32'(base_c), s_axi_wdata, s_axi_wstrb));
            REG_CTRL: if (s_axi_wstrb[0]) begin
              start  <= s_axi_wdata[0];
              accum  <= s_axi_wdata[1];
              irq_en <= s_axi_wdata[2];
              abort  <= s_axi_wdata[3];
            end
            REG_STATUS: done_clr <= s_axi_wstrb[0] && s_axi_wdata[1];
            default: ;
          endcase
      end
      s_axi_arready <= s_axi_arvalid && !s_axi_arready && !s_axi_rvalid;
      if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
      if (s_axi_arready && s_axi_arvalid) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd_hit ? rd_val : '0;
        s_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: tiling FSM and address generator driving A/B fetch, PE array stepping and C stores.
// Define GEMM_PERF_CNT_EN to add the STALL and TILES performance counters.
module gemm_tile_sequencer import gemm_pkg::*; #(
  parameter int PE_ROWS    = 8,
  parameter int PE_COLS    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16,
  parameter int ARRAY_LAT  = PE_ROWS + PE_COLS - 1,
  parameter int A_STRIDE   = 16,
  parameter int B_STRIDE   = 16,
  parameter int C_STRIDE   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  a_req_valid,
  input  logic                  a_req_ready,
  output logic [ADDR_WIDTH-1:0] a_req_addr,
  output logic                  b_req_valid,
  input  logic                  b_req_ready,
  output logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic                  ab_rsp_valid,
  output logic                  pe_clr,
  output logic                  pe_step,
  output logic                  c_req_valid,
  input  logic                  c_req_ready,
  output logic [ADDR_WIDTH-1:0] c_req_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  irq
);
  localparam int LW = $clog2(ARRAY_LAT + 1);
  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);
  logic [DIM_WIDTH-1:0] m, n, k, tm, tn, k_cnt, tiles_m, tiles_n;
  logic [ADDR_WIDTH-1:0] base_a, base_b, base_c;
  logic accum, irq_en, start, abort, done_clr, err, abort_pend, a_ok, b_ok, last_tile;
  logic [31:0] cycles;
  logic [LW-1:0] drain;
  state_t state;
`ifdef GEMM_PERF_CNT_EN
  logic [31:0] stall, tiles;
  logic stalled;
  assign stalled = (state == S_FETCH && !(a_ok && b_ok)) || (state == S_WAIT && !ab_rsp_valid) ||
                   (state == S_STORE && !c_req_ready);
`endif
  gemm_axil_regs #(.ADDR_WIDTH(ADDR_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_regs (
    .clk, .rst_n,
    .s_axi_awaddr, .s_axi_awvalid, .s_axi_awready, .s_axi_wdata, .s_axi_wstrb, .s_axi_wvalid,
    .s_axi_wready, .s_axi_bresp, .s_axi_bvalid, .s_axi_bready, .s_axi_araddr, .s_axi_arvalid,
    .s_axi_arready, .s_axi_rdata, .s_axi_rresp, .s_axi_rvalid, .s_axi_rready,
    .m, .n, .k, .base_a, .base_b, .base_c, .accum, .irq_en, .start, .abort, .done_clr,
    .busy, .done, .err,
`ifdef GEMM_PERF_CNT_EN
    .stall, .tiles,
`endif
    .cycles
  );
  assign busy = state != S_IDLE && state != S_DONE;
  assign irq = done & irq_en;
  assign a_ok = !a_req_valid || a_req_ready;
  assign b_ok = !b_req_valid || b_req_ready;
  assign last_tile = tm == tiles_m - ONE && tn == tiles_n - ONE;
  assign a_req_addr = a_req_valid ? base_a + (ADDR_WIDTH'(tm) * ADDR_WIDTH'(k) + ADDR_WIDTH'(k_cnt)) * ADDR_WIDTH'(A_STRIDE) : '0;
  assign b_req_addr = b_req_valid ? base_b + (ADDR_WIDTH'(tn) * ADDR_WIDTH'(k) + ADDR_WIDTH'(k_cnt)) * ADDR_WIDTH'(B_STRIDE) : '0;
  assign c_req_addr = c_req_valid ? base_c + (ADDR_WIDTH'(tm) * ADDR_WIDTH'(tiles_n) + ADDR_WIDTH'(tn)) * ADDR_WIDTH'(C_STRIDE) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {a_req_valid, b_req_valid, c_req_valid, pe_clr, pe_step, done, err, abort_pend} <= '0;
      {tm, tn, k_cnt, tiles_m, tiles_n} <= '0;
      drain <= '0;
      cycles <= '0;
`ifdef GEMM_PERF_CNT_EN
      stall <= '0;
      tiles <= '0;
`endif
    end else begin
      pe_clr <= 1'b0;
      pe_step <= 1'b0;
      if (done_clr) begin
        done <= 1'b0;
        err <= 1'b0;
      end
      if (abort && busy) abort_pend <= 1'b1;
      if (busy && cycles != '1) cycles <= cycles + 32'd1;
`ifdef GEMM_PERF_CNT_EN
      if (stalled && stall != '1) stall <= stall + 32'd1;
`endif
      case (state)
        S_IDLE: if (start) begin
          state <= S_CHECK;
          cycles <= '0;
          abort_pend <= 1'b0;
`ifdef GEMM_PERF_CNT_EN
          stall <= '0;
          tiles <= '0;
`endif
        end
        S_CHECK: if (m == '0 || n == '0 || k == '0) begin
          state <= S_DONE;
          done <= 1'b1;
          err <= 1'b1;
        end else begin
          tiles_m <= DIM_WIDTH'((32'(m) + PE_ROWS - 1) / PE_ROWS);
          tiles_n <= DIM_WIDTH'((32'(n) + PE_COLS - 1) / PE_COLS);
          {tm, tn, k_cnt} <= '0;
          state <= S_CLEAR;
        end
        S_CLEAR: begin
          pe_clr <= !accum;
          if (abort_pend) begin
            state <= S_DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= S_FETCH;
            a_req_valid <= 1'b1;
            b_req_valid <= 1'b1;
          end
        end
        S_FETCH: begin
          if (a_req_ready) a_req_valid <= 1'b0;
          if (b_req_ready) b_req_valid <= 1'b0;
          if (a_ok && b_ok) state <= S_WAIT;
        end
        S_WAIT: if (ab_rsp_valid) begin
          pe_step <= 1'b1;
          k_cnt <= k_cnt + ONE;
          if (k_cnt + ONE == k) begin
            state <= S_DRAIN;
            drain <= '0;
          end else if (abort_pend) begin
            state <= S_DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= S_FETCH;
            a_req_valid <= 1'b1;
            b_req_valid <= 1'b1;
          end
        end
        S_DRAIN: if (drain == LW'(ARRAY_LAT - 1)) begin
          if (abort_pend) begin
            state <= S_DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= S_STORE;
            c_req_valid <= 1'b1;
          end
        end else drain <= drain + LW'(1);
        S_STORE: if (c_req_ready) begin
          c_req_valid <= 1'b0;
`ifdef GEMM_PERF_CNT_EN
          if (tiles != '1) tiles <= tiles + 32'd1;
`endif
          if (last_tile) begin
            state <= S_DONE;
            done <= 1'b1;
          end else begin
            k_cnt <= '0;
            tn <= tn == tiles_n - ONE ? '0 : tn + ONE;
            tm <= tn == tiles_n - ONE ? tm + ONE : tm;
            state <= S_CLEAR;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: randomized scoreboard bench; a tile-walk model predicts every A/B/C request address.
module tb_gemm_tile_sequencer;
  localparam int AW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = 4'hF;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic a_req_valid, b_req_valid, c_req_valid, pe_clr, pe_step, busy, done, irq;
  logic a_req_ready = 1'b0, b_req_ready = 1'b0, ab_rsp_valid = 1'b0, c_req_ready = 1'b0;
  logic [AW-1:0] a_req_addr, b_req_addr, c_req_addr;
  int checks = 0, errors = 0;
  int steps = 0, clrs = 0, busy_cyc = 0, a_hs = 0, exp_steps = 0, exp_clrs = 0;
  bit bp = 0, hold_rsp = 0;
  logic [AW-1:0] a_q[$], b_q[$], c_q[$];
  logic [AW-1:0] a_prev, b_prev, c_prev;
  bit a_hold = 0, b_hold = 0, c_hold = 0;

  gemm_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .ab_rsp_valid(ab_rsp_valid), .pe_clr(pe_clr), .pe_step(pe_step),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_addr(c_req_addr),
    .busy(busy), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-side responders: full speed, or random backpressure when bp is set.
  initial forever begin
    @(posedge clk); #1;
    a_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    b_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    c_req_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
    ab_rsp_valid = hold_rsp ? 1'b0 : bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake and enforces address stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_hold = 0; b_hold = 0; c_hold = 0;
    end else begin
      if (a_hold) check("a_stable", {a_req_valid, a_req_addr}, {1'b1, a_prev});
      if (b_hold) check("b_stable", {b_req_valid, b_req_addr}, {1'b1, b_prev});
      if (c_hold) check("c_stable", {c_req_valid, c_req_addr}, {1'b1, c_prev});
      if (a_req_valid && a_req_ready) begin
        a_hs++;
        if (a_q.size() == 0) begin checks++; errors++; $display("FAIL a_unexpected: got 0x%0h expected none", a_req_addr); end
        else check("a_addr", a_req_addr, a_q.pop_front());
      end
      if (b_req_valid && b_req_ready) begin
        if (b_q.size() == 0) begin checks++; errors++; $display("FAIL b_unexpected: got 0x%0h expected none", b_req_addr); end
        else check("b_addr", b_req_addr, b_q.pop_front());
      end
      if (c_req_valid && c_req_ready) begin
        if (c_q.size() == 0) begin checks++; errors++; $display("FAIL c_unexpected: got 0x%0h expected none", c_req_addr); end
        else check("c_addr", c_req_addr, c_q.pop_front());
      end
      a_hold = a_req_valid && !a_req_ready; a_prev = a_req_addr;
      b_hold = b_req_valid && !b_req_ready; b_prev = b_req_addr;
      c_hold = c_req_valid && !c_req_ready; c_prev = c_req_addr;
      if (pe_step) steps++;
      if (pe_clr) clrs++;
      if (busy) busy_cyc++;
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 20);
    if (!awready) begin checks++; errors++; $display("FAIL aw_timeout: got no awready expected one"); end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 20);
    if (!bvalid) begin checks++; errors++; $display("FAIL b_timeout: got no bvalid expected one"); end
    resp = bresp;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 20);
    if (!arready) begin checks++; errors++; $display("FAIL ar_timeout: got no arready expected one"); end
    @(posedge clk); #1;
    arvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rvalid && t < 20);
    if (!rvalid) begin checks++; errors++; $display("FAIL r_timeout: got no rvalid expected one"); end
    data = rdata; resp = rresp;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic [31:0] d; logic [1:0] r;
    axi_read(addr, d, r);
    check(name, {r, d}, {2'b00, exp});
  endtask

  // Reference tile walk: tn fastest, then tm; K words of A and B per tile, one C store per tile.
  task automatic push_model(input int m, input int n, input int k, input logic [31:0] ba, input logic [31:0] bb,
                            input logic [31:0] bc, input bit accum);
    int tmn, tnn;
    tmn = (m + 7) / 8; tnn = (n + 7) / 8;
    if (m == 0 || n == 0 || k == 0) begin tmn = 0; tnn = 0; end
    for (int tm = 0; tm < tmn; tm++)
      for (int tn = 0; tn < tnn; tn++) begin
        for (int kk = 0; kk < k; kk++) begin
          a_q.push_back(ba + 32'((tm * k + kk) * 16));
          b_q.push_back(bb + 32'((tn * k + kk) * 16));
        end
        c_q.push_back(bc + 32'((tm * tnn + tn) * 256));
      end
    exp_steps = tmn * tnn * k;
    exp_clrs = accum ? 0 : tmn * tnn;
  endtask

  task automatic start_run(input int m, input int n, input int k, input logic [31:0] ba, input logic [31:0] bb,
                           input logic [31:0] bc, input bit accum, input bit ien);
    logic [1:0] r;
    logic [1:0] acc;
    acc = 0;
    axi_write(32'h00, 32'(m), r); acc |= r;
    axi_write(32'h04, 32'(n), r); acc |= r;
    axi_write(32'h08, 32'(k), r); acc |= r;
    axi_write(32'h10, ba, r); acc |= r;
    axi_write(32'h14, bb, r); acc |= r;
    axi_write(32'h18, bc, r); acc |= r;
    axi_write(32'h1C, 32'h2, r); acc |= r;
    check("cfg_bresp", acc, 2'b00);
    push_model(m, n, k, ba, bb, bc, accum);
    steps = 0; clrs = 0; busy_cyc = 0; a_hs = 0;
    axi_write(32'h0C, {29'd0, ien, accum, 1'b1}, r);
  endtask

  task automatic finish_run(input string tag, input int bound, input bit exp_err);
    int t = 0;
    while (!done && t < bound) begin @(negedge clk); t++; end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_steps"}, steps, exp_steps);
    check({tag, "_clrs"}, clrs, exp_clrs);
    check({tag, "_left"}, a_q.size() + b_q.size() + c_q.size(), 0);
    read_check({tag, "_status"}, 32'h1C, {29'd0, exp_err, 1'b1, 1'b0});
    read_check({tag, "_cycles"}, 32'h20, 32'(busy_cyc));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {a_req_valid, b_req_valid, c_req_valid, pe_clr, pe_step, busy, done, irq,
                          awready, wready, bvalid, arready, rvalid}, 13'd0);
    check({tag, "_addr"}, a_req_addr | b_req_addr | c_req_addr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d; logic [1:0] r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    read_check("rst_m", 32'h00, 32'd64);
    read_check("rst_k", 32'h08, 32'd64);
    // single tile, K=8
    start_run(8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    finish_run("s1", 500, 0);
    // two row tiles with irq
    start_run(16, 8, 2, 32'h1000, 32'h2000, 32'h3000, 0, 1);
    finish_run("s2", 500, 0);
    check("s2_irq", irq, 1'b1);
    axi_write(32'h1C, 32'h2, r);
    @(negedge clk);
    check("s2_irq_clr", {irq, done}, 2'b00);
    // zero K: error, no traffic, quick finish
    start_run(8, 8, 0, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    finish_run("s3", 3, 1);
    // same as first run under random backpressure
    bp = 1;
    start_run(8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    finish_run("s4", 3000, 0);
    bp = 0;
    // config write while busy is rejected
    hold_rsp = 1;
    start_run(8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    repeat (4) @(negedge clk);
    axi_write(32'h00, 32'd5, r);
    check("s5_busy_bresp", r, 2'b10);
    read_check("s5_m_kept", 32'h00, 32'd8);
    hold_rsp = 0;
    finish_run("s5", 500, 0);
    axi_read(32'h40, d, r);
    check("s5_unmapped", {r, d}, {2'b10, 32'd0});
    // randomized geometries, bases, accumulate mode and backpressure
    bp = 1;
    for (int i = 0; i < 5; i++) begin
      start_run($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 6),
                $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
      finish_run("rnd", 8000, 0);
    end
    bp = 0;
    // reset while waiting for operands
    hold_rsp = 1;
    start_run(8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    for (int t = 0; t < 50 && a_hs == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("s6_busy_before", busy, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    a_q.delete(); b_q.delete(); c_q.delete();
    #1;
    check_idle_outputs("s6_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_rsp = 0;
    read_check("s6_m", 32'h00, 32'd64);
    read_check("s6_ctrl", 32'h0C, 32'd0);
    read_check("s6_status", 32'h1C, 32'd0);
    start_run(8, 8, 8, 32'h1000, 32'h2000, 32'h3000, 0, 0);
    finish_run("s6", 500, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
